// File: rtl/e_mem_port_arbiter.sv
// Round-robin arbiter for the east-edge external memory port: two requesters share
// one port, one transaction in flight at a time, fixed read latency.
module e_mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  UserCLK,
  input  logic                  resetn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;

  // The winner's address/data are latched straight into the memory-side output
  // registers, so they double as the transaction record.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    addr_d       = mem_addr_o;
    wdata_d      = mem_wdata_o;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? ~last_grant_q : req1;
          we_d    = grant_d ? we1 : we0;
          addr_d  = grant_d ? addr1 : addr0;
          wdata_d = grant_d ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = LAT_INIT;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (grant_q) rdata1_d = mem_rdata_i;
          else         rdata0_d = mem_rdata_i;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with
  // the cycle the FSM spends in the matching state.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      lat_cnt_q    <= 4'd0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy_o       <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      mem_en_o     <= (state_d == ISSUE);
      mem_we_o     <= (state_d == ISSUE) && we_d;
      mem_addr_o   <= addr_d;
      mem_wdata_o  <= wdata_d;
      ack0         <= (state_d == RESP) && !grant_d;
      ack1         <= (state_d == RESP) && grant_d;
      busy_o       <= (state_d != IDLE);
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
    end
  end

endmodule
